// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states,
// default bus timeout and the op legality/alignment check.
package lsu_pkg;

  localparam int TIMEOUT_DEFAULT = 255;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Store width 11 has no RV32I meaning, so it is rejected alongside bit2=1.
  function automatic logic op_bad(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic illegal;
    logic mis;
    illegal = we ? (f3[2] || (f3[1:0] == 2'b11))
                 : ((f3 == 3'b011) || (f3[2:1] == 2'b11));
    mis = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    return illegal || mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: store byte enables and data
// replication, load lane extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    be    = 4'b0000;
    wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign shifted = bus_rdata >> {addr_lo, 3'b000};
  assign byte_s  = shifted[7:0];
  assign half_s  = shifted[15:0];

  always_comb begin
    load_data = bus_rdata;
    case (funct3)
      F3_B:    load_data = 32'(byte_s);
      F3_BU:   load_data = {24'd0, shifted[7:0]};
      F3_H:    load_data = 32'(half_s);
      F3_HU:   load_data = {16'd0, shifted[15:0]};
      default: load_data = bus_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: latches one CPU memory op, runs a single-beat bus
// transaction with timeout, and returns the aligned/extended load result.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_req,
  input  logic        I_we,
  input  logic [2:0]  I_funct3,
  input  logic [31:0] I_address,
  input  logic [31:0] I_data,
  output logic [31:0] O_data,
  output logic        O_stall,
  output logic        O_done,
  output logic        O_misaligned,
  output logic        O_err,
  output logic        O_bus_valid,
  input  logic        I_bus_ready,
  output logic        O_bus_we,
  output logic [31:0] O_bus_addr,
  output logic [31:0] O_bus_wdata,
  output logic [3:0]  O_bus_be,
  input  logic [31:0] I_bus_rdata,
  input  logic        I_bus_rvalid
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state, state_nxt;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [31:0]       addr_q;
  logic [31:0]       data_q;
  logic [31:0]       rdata_q;
  logic              mis_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              accept;
  logic              rd_cap;
  logic              err_set;
  logic              timeout_hit;
  logic [3:0]        be_al;
  logic [31:0]       wdata_al;
  logic [31:0]       load_al;

  assign accept      = (state == S_IDLE) && I_req;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    rd_cap    = 1'b0;
    err_set   = 1'b0;
    case (state)
      S_IDLE: if (I_req) state_nxt = op_bad(I_we, I_funct3, I_address[1:0]) ? S_DONE : S_REQ;
      S_REQ: begin
        if (I_bus_ready && (we_q || I_bus_rvalid)) begin
          state_nxt = S_DONE;
          rd_cap    = !we_q;
        end else if (timeout_hit) begin
          state_nxt = S_DONE;
          err_set   = 1'b1;
        end else if (I_bus_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (I_bus_rvalid) begin
          state_nxt = S_DONE;
          rd_cap    = 1'b1;
        end else if (timeout_hit) begin
          state_nxt = S_DONE;
          err_set   = 1'b1;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q    <= I_we;
        f3_q    <= I_funct3;
        addr_q  <= I_address;
        data_q  <= I_data;
        mis_q   <= op_bad(I_we, I_funct3, I_address[1:0]);
        err_q   <= 1'b0;
        rdata_q <= 32'd0;
        cnt_q   <= '0;
      end
      if ((state == S_REQ) || (state == S_WAIT)) cnt_q <= cnt_q + CNT_W'(1);
      if (rd_cap) rdata_q <= I_bus_rdata;
      if (err_set) err_q <= 1'b1;
    end
  end

  lsu_align u_align (
    .funct3     (f3_q),
    .addr_lo    (addr_q[1:0]),
    .store_data (data_q),
    .bus_rdata  (rdata_q),
    .be         (be_al),
    .wdata      (wdata_al),
    .load_data  (load_al)
  );

  // Bus side is only driven while a request is outstanding.
  assign O_bus_valid  = (state == S_REQ);
  assign O_bus_we     = O_bus_valid && we_q;
  assign O_bus_addr   = O_bus_valid ? {addr_q[31:2], 2'b00} : 32'd0;
  assign O_bus_wdata  = O_bus_we ? wdata_al : 32'd0;
  assign O_bus_be     = O_bus_we ? be_al : 4'b0000;

  assign O_stall      = accept || (state == S_REQ) || (state == S_WAIT);
  assign O_done       = (state == S_DONE);
  assign O_misaligned = O_done && mis_q;
  assign O_err        = O_done && err_q;
  assign O_data       = (O_done && !we_q && !mis_q && !err_q) ? load_al : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with an expected-result queue that is
// filled when an op is issued and drained when O_done appears.
module tb_load_store_unit;

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b0;
  logic        I_req = 1'b0;
  logic        I_we = 1'b0;
  logic [2:0]  I_funct3 = 3'd0;
  logic [31:0] I_address = 32'd0;
  logic [31:0] I_data = 32'd0;
  logic [31:0] O_data;
  logic        O_stall;
  logic        O_done;
  logic        O_misaligned;
  logic        O_err;
  logic        O_bus_valid;
  logic        I_bus_ready = 1'b0;
  logic        O_bus_we;
  logic [31:0] O_bus_addr;
  logic [31:0] O_bus_wdata;
  logic [3:0]  O_bus_be;
  logic [31:0] I_bus_rdata = 32'd0;
  logic        I_bus_rvalid = 1'b0;

  typedef struct {
    logic        mis;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  load_store_unit #(.TIMEOUT(255)) dut (
    .I_clk        (I_clk),
    .I_rst        (I_rst),
    .I_req        (I_req),
    .I_we         (I_we),
    .I_funct3     (I_funct3),
    .I_address    (I_address),
    .I_data       (I_data),
    .O_data       (O_data),
    .O_stall      (O_stall),
    .O_done       (O_done),
    .O_misaligned (O_misaligned),
    .O_err        (O_err),
    .O_bus_valid  (O_bus_valid),
    .I_bus_ready  (I_bus_ready),
    .O_bus_we     (O_bus_we),
    .O_bus_addr   (O_bus_addr),
    .O_bus_wdata  (O_bus_wdata),
    .O_bus_be     (O_bus_be),
    .I_bus_rdata  (I_bus_rdata),
    .I_bus_rvalid (I_bus_rvalid)
  );

  always #5 I_clk = ~I_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge I_clk);
    #1;
  endtask

  // Drive one request for a single cycle; optionally queue its expected result.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input bit push, input logic mis,
                       input logic err, input logic [31:0] data);
    exp_t e;
    I_req = 1'b1; I_we = we; I_funct3 = f3; I_address = a; I_data = d;
    #1;
    chk("stall_on_req", O_stall, 1'b1);
    if (push) begin
      e.mis = mis; e.err = err; e.data = data;
      sb.push_back(e);
    end
    step();
    I_req = 1'b0; I_we = 1'b0; I_funct3 = 3'd0; I_address = 32'd0; I_data = 32'd0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n;
    exp_t e;
    n = 0;
    while (!O_done && n < limit) begin
      step();
      n++;
    end
    chk({tag, "_done"}, O_done, 1'b1);
    if (O_done) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk({tag, "_data"}, O_data, e.data);
        chk({tag, "_mis"}, O_misaligned, e.mis);
        chk({tag, "_err"}, O_err, e.err);
        chk({tag, "_stall_done"}, O_stall, 1'b0);
        chk({tag, "_valid_done"}, O_bus_valid, 1'b0);
      end
      step();
      chk({tag, "_done_once"}, O_done, 1'b0);
    end
  endtask

  initial begin
    int n;
    // Reset
    step(); step();
    chk("rst_valid", O_bus_valid, 1'b0);
    chk("rst_stall", O_stall, 1'b0);
    chk("rst_done", O_done, 1'b0);
    chk("rst_addr", O_bus_addr, 32'd0);
    chk("rst_data", O_data, 32'd0);
    I_rst = 1'b1;
    step();

    // SW 0x100, ready after two wait cycles
    issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'd0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      I_bus_ready = (i == 2);
      if (O_bus_valid) n++;
      chk("sw_addr", O_bus_addr, 32'h100);
      chk("sw_be", {28'd0, O_bus_be}, 32'hF);
      chk("sw_wdata", O_bus_wdata, 32'hDEADBEEF);
      chk("sw_we", O_bus_we, 1'b1);
      step();
    end
    I_bus_ready = 1'b0;
    chk("sw_valid_cycles", n, 32'd3);
    wait_done("sw", 2);

    // LB 0x203 via WAIT state
    issue(1'b0, 3'b000, 32'h203, 32'd0, 1'b1, 1'b0, 1'b0, 32'hFFFFFF80);
    chk("lb_be", {28'd0, O_bus_be}, 32'd0);
    chk("lb_addr", O_bus_addr, 32'h200);
    chk("lb_valid", O_bus_valid, 1'b1);
    I_bus_ready = 1'b1;
    step();
    I_bus_ready = 1'b0;
    chk("lb_wait_valid", O_bus_valid, 1'b0);
    chk("lb_wait_stall", O_stall, 1'b1);
    I_bus_rvalid = 1'b1; I_bus_rdata = 32'h80FFFF7F;
    step();
    I_bus_rvalid = 1'b0; I_bus_rdata = 32'd0;
    wait_done("lb", 2);

    // LBU 0x203 with ready and rvalid together
    issue(1'b0, 3'b100, 32'h203, 32'd0, 1'b1, 1'b0, 1'b0, 32'h00000080);
    I_bus_ready = 1'b1; I_bus_rvalid = 1'b1; I_bus_rdata = 32'h80FFFF7F;
    step();
    I_bus_ready = 1'b0; I_bus_rvalid = 1'b0; I_bus_rdata = 32'd0;
    wait_done("lbu", 2);

    // SH 0x302
    issue(1'b1, 3'b001, 32'h302, 32'h0000ABCD, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("sh_be", {28'd0, O_bus_be}, 32'hC);
    chk("sh_wdata", O_bus_wdata, 32'hABCDABCD);
    chk("sh_addr", O_bus_addr, 32'h300);
    I_bus_ready = 1'b1;
    step();
    I_bus_ready = 1'b0;
    wait_done("sh", 2);

    // SB 0x401: byte replicated, lane 1 enabled
    issue(1'b1, 3'b000, 32'h401, 32'h123456A5, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("sb_be", {28'd0, O_bus_be}, 32'h2);
    chk("sb_wdata", O_bus_wdata, 32'hA5A5A5A5);
    I_bus_ready = 1'b1;
    step();
    I_bus_ready = 1'b0;
    wait_done("sb", 2);

    // Misaligned LH 0x301: no bus traffic, done next cycle
    issue(1'b0, 3'b001, 32'h301, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0);
    chk("lh_mis_valid", O_bus_valid, 1'b0);
    wait_done("lh_mis", 0);

    // Misaligned SW and illegal load width
    issue(1'b1, 3'b010, 32'h102, 32'h1, 1'b1, 1'b1, 1'b0, 32'd0);
    chk("sw_mis_valid", O_bus_valid, 1'b0);
    wait_done("sw_mis", 0);
    issue(1'b0, 3'b011, 32'h100, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0);
    wait_done("ld_ill", 0);
    issue(1'b1, 3'b101, 32'h100, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0);
    wait_done("st_ill", 0);

    // LH / LHU upper half sign and zero extension
    issue(1'b0, 3'b001, 32'h402, 32'd0, 1'b1, 1'b0, 1'b0, 32'hFFFFBEEF);
    I_bus_ready = 1'b1; I_bus_rvalid = 1'b1; I_bus_rdata = 32'hBEEF1234;
    step();
    I_bus_ready = 1'b0; I_bus_rvalid = 1'b0;
    wait_done("lh", 2);
    issue(1'b0, 3'b101, 32'h402, 32'd0, 1'b1, 1'b0, 1'b0, 32'h0000BEEF);
    I_bus_ready = 1'b1; I_bus_rvalid = 1'b1; I_bus_rdata = 32'hBEEF1234;
    step();
    I_bus_ready = 1'b0; I_bus_rvalid = 1'b0; I_bus_rdata = 32'd0;
    wait_done("lhu", 2);

    // Timeout: ready once, rvalid never
    issue(1'b0, 3'b010, 32'h500, 32'd0, 1'b1, 1'b0, 1'b1, 32'd0);
    I_bus_ready = 1'b1;
    step();
    I_bus_ready = 1'b0;
    n = 1;
    while (!O_done && n < 400) begin
      if (O_stall) n++;
      step();
    end
    chk("to_cycles", n, 32'd255);
    wait_done("to", 1);

    // Reset while REQ waits for ready
    issue(1'b1, 3'b010, 32'h600, 32'h55AA55AA, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("rst_mid_valid_before", O_bus_valid, 1'b1);
    I_rst = 1'b0;
    step();
    I_rst = 1'b1;
    chk("rst_mid_valid", O_bus_valid, 1'b0);
    chk("rst_mid_stall", O_stall, 1'b0);
    chk("rst_mid_addr", O_bus_addr, 32'd0);
    chk("rst_mid_done", O_done, 1'b0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (O_done) n++;
      step();
    end
    chk("rst_mid_no_done", n, 32'd0);

    // LW after reset completes normally
    issue(1'b0, 3'b010, 32'h700, 32'd0, 1'b1, 1'b0, 1'b0, 32'h12345678);
    chk("lw_addr", O_bus_addr, 32'h700);
    I_bus_ready = 1'b1; I_bus_rvalid = 1'b1; I_bus_rdata = 32'h12345678;
    step();
    I_bus_ready = 1'b0; I_bus_rvalid = 1'b0; I_bus_rdata = 32'd0;
    wait_done("lw", 2);

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
